mem_port_arbiter: RTL and testbench

//   Shares the single-port instruction/data memory of the multi-cycle CPU between
//   two requesters: the CPU memory stage (port C) and a DMA/program loader (port D).

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU memory stage (C) and a DMA/loader (D).
// One transaction at a time: IDLE -> ACCESS -> WAIT (reads) -> DONE -> IDLE.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int LAT_W = 3;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              dma_wins;

  // DMA only beats a pending CPU request once the CPU has starved it long enough.
  assign dma_wins = dma_req && (!cpu_req || (starve_cnt_q == SC_W'(STARVE_MAX)));

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    we_d         = we_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (!dma_req) starve_cnt_d = '0;
        if (cpu_req || dma_req) begin
          state_d = ACCESS;
          owner_d = dma_wins;
          if (dma_wins) begin
            we_d         = dma_we;
            addr_d       = dma_addr;
            wdata_d      = dma_wdata;
            starve_cnt_d = '0;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            if (dma_req && (starve_cnt_q != SC_W'(STARVE_MAX)))
              starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d   = WAIT;
          lat_cnt_d = LAT_W'(MEM_LAT);
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == LAT_W'(1)) begin
          state_d = DONE;
          if (owner_q) dma_rdata_d = mem_rdata;
          else         cpu_rdata_d = mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign mem_read  = (state_q == ACCESS) && !we_q;
  assign mem_write = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == DONE) && !owner_q;
  assign dma_ack   = (state_q == DONE) && owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) against a
// transaction-timeline model, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [2];
  logic        cpu_req   [2];
  logic        cpu_we    [2];
  logic [31:0] cpu_addr  [2];
  logic [31:0] cpu_wdata [2];
  logic        cpu_ack   [2];
  logic [31:0] cpu_rdata [2];
  logic        dma_req   [2];
  logic        dma_we    [2];
  logic [31:0] dma_addr  [2];
  logic [31:0] dma_wdata [2];
  logic        dma_ack   [2];
  logic [31:0] dma_rdata [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];
  logic        owner     [2];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT0), .STARVE_MAX(SMAX)) dut0 (
    .clk(clk), .reset(reset[0]),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
    .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]),
    .dma_ack(dma_ack[0]), .dma_rdata(dma_rdata[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .reset(reset[1]),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
    .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]),
    .dma_ack(dma_ack[1]), .dma_rdata(dma_rdata[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1])
  );

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : ({a[15:0], ~a[15:0]} ^ 32'h3C3C_0F0F);
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s u%0d cyc %0d: got %h, expected %h", nm, u, cyc, act, exp);
    end
  endtask

  // Timeline model: a granted transaction occupies offsets 1..dur after its sample cycle.
  bit          m_valid [2];
  bit          m_busy  [2];
  bit          m_own   [2];
  bit          m_we    [2];
  int          m_k     [2];
  int          m_dur   [2];
  int          m_starve[2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rd_cpu[2];
  logic [31:0] m_rd_dma[2];
  bit          hist_rd  [2][8];
  logic [31:0] hist_addr[2][8];
  int          m_idx;
  bit          e_acc, e_fin, m_dwin;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (m_valid[u]) begin
        e_acc = m_busy[u] && (m_k[u] == 1);
        e_fin = m_busy[u] && (m_k[u] == m_dur[u]);
        if (e_fin && !m_we[u]) begin
          if (m_own[u]) m_rd_dma[u] = rd_fn(m_addr[u]);
          else          m_rd_cpu[u] = rd_fn(m_addr[u]);
        end
        chk("busy",      u, 32'(busy[u]),      32'(m_busy[u]));
        chk("cpu_ack",   u, 32'(cpu_ack[u]),   32'(e_fin && !m_own[u]));
        chk("dma_ack",   u, 32'(dma_ack[u]),   32'(e_fin && m_own[u]));
        chk("mem_read",  u, 32'(mem_read[u]),  32'(e_acc && !m_we[u]));
        chk("mem_write", u, 32'(mem_write[u]), 32'(e_acc && m_we[u]));
        chk("owner",     u, 32'(owner[u]),     32'(m_own[u]));
        chk("cpu_rdata", u, cpu_rdata[u], m_rd_cpu[u]);
        chk("dma_rdata", u, dma_rdata[u], m_rd_dma[u]);
        if (e_acc) begin
          chk("mem_addr", u, mem_addr[u], m_addr[u]);
          if (m_we[u]) chk("mem_wdata", u, mem_wdata[u], m_wdata[u]);
        end
      end
      // memory macro: data for a read strobed in cycle r is presented in cycle r+LAT
      hist_rd[u][cyc % 8]   = mem_read[u];
      hist_addr[u][cyc % 8] = mem_addr[u];
      m_idx = (cyc + 8 - lat_of(u)) % 8;
      mem_rdata[u] = hist_rd[u][m_idx] ? rd_fn(hist_addr[u][m_idx])
                                       : (32'hBAD0_0000 | (cyc & 32'h0000_FFFF));
      if (reset[u]) begin
        m_valid[u]  = 1'b1;
        m_busy[u]   = 1'b0;
        m_own[u]    = 1'b0;
        m_we[u]     = 1'b0;
        m_k[u]      = 0;
        m_dur[u]    = 0;
        m_starve[u] = 0;
        m_addr[u]   = '0;
        m_wdata[u]  = '0;
        m_rd_cpu[u] = '0;
        m_rd_dma[u] = '0;
      end else if (m_valid[u]) begin
        if (m_busy[u]) begin
          if (m_k[u] == m_dur[u]) m_busy[u] = 1'b0;
          else                    m_k[u]++;
        end else begin
          if (!dma_req[u]) m_starve[u] = 0;
          if (cpu_req[u] || dma_req[u]) begin
            m_dwin = dma_req[u] && (!cpu_req[u] || (m_starve[u] >= SMAX));
            m_own[u] = m_dwin;
            if (m_dwin) begin
              m_we[u] = dma_we[u]; m_addr[u] = dma_addr[u]; m_wdata[u] = dma_wdata[u];
              m_starve[u] = 0;
            end else begin
              m_we[u] = cpu_we[u]; m_addr[u] = cpu_addr[u]; m_wdata[u] = cpu_wdata[u];
              if (dma_req[u]) m_starve[u] = (m_starve[u] < SMAX) ? m_starve[u] + 1 : SMAX;
            end
            m_busy[u] = 1'b1;
            m_k[u]    = 1;
            m_dur[u]  = m_we[u] ? 2 : 2 + lat_of(u);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (call right after tick) and hold it until its ack.
  task automatic run_txn(input int u, input bit dma, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input int drop_at,
                         output int s_off, output int a_off, output logic [31:0] rd,
                         output logic [31:0] s_addr, output logic [31:0] s_wd,
                         output int n_rd, output int n_oth);
    int t0;
    if (dma) begin
      dma_req[u] = 1'b1; dma_we[u] = we; dma_addr[u] = a; dma_wdata[u] = wd;
    end else begin
      cpu_req[u] = 1'b1; cpu_we[u] = we; cpu_addr[u] = a; cpu_wdata[u] = wd;
    end
    t0 = cyc; s_off = -1; a_off = -1; rd = '0; s_addr = '0; s_wd = '0; n_rd = 0; n_oth = 0;
    for (int i = 0; i < 40 && a_off < 0; i++) begin
      @(negedge clk);
      if ((mem_read[u] || mem_write[u]) && s_off < 0) begin
        s_off = cyc - t0; s_addr = mem_addr[u]; s_wd = mem_wdata[u];
      end
      if (mem_read[u]) n_rd++;
      if (dma ? cpu_ack[u] : dma_ack[u]) n_oth++;
      if (dma ? dma_ack[u] : cpu_ack[u]) begin
        a_off = cyc - t0;
        rd = dma ? dma_rdata[u] : cpu_rdata[u];
      end
      tick();
      if (drop_at > 0 && (cyc - t0) == drop_at) begin
        if (dma) dma_req[u] = 1'b0; else cpu_req[u] = 1'b0;
      end
    end
    if (dma) dma_req[u] = 1'b0; else cpu_req[u] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s_off, a_off, n_rd, n_oth, g, n, cnt_d, cnt_c;
    logic [31:0] rd, sa, sw;
    int seq [10];
    int s_c [3];
    int a_c [3];

    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1;
      cpu_req[u] = 1'b0; cpu_we[u] = 1'b0; cpu_addr[u] = '0; cpu_wdata[u] = '0;
      dma_req[u] = 1'b0; dma_we[u] = 1'b0; dma_addr[u] = '0; dma_wdata[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    chk("rst_busy",  0, 32'(busy[0]),  0);
    chk("rst_owner", 0, 32'(owner[0]), 0);
    chk("rst_cpu_rdata", 0, cpu_rdata[0], 0);
    chk("rst_dma_rdata", 1, dma_rdata[1], 0);

    // CPU read of 0x40, MEM_LAT=1
    tick();
    run_txn(0, 1'b0, 1'b0, 32'h40, 32'h0, 0, s_off, a_off, rd, sa, sw, n_rd, n_oth);
    chk("cpu_rd_strobe_off", 0, s_off, 1);
    chk("cpu_rd_ack_off",    0, a_off, 3);
    chk("cpu_rd_data",       0, rd, 32'hDEADBEEF);
    chk("cpu_rd_addr",       0, sa, 32'h40);
    chk("cpu_rd_no_dma_ack", 0, n_oth, 0);

    // DMA write 0x10 <- 0x1234
    run_txn(0, 1'b1, 1'b1, 32'h10, 32'h1234, 0, s_off, a_off, rd, sa, sw, n_rd, n_oth);
    chk("dma_wr_strobe_off", 0, s_off, 1);
    chk("dma_wr_ack_off",    0, a_off, 2);
    chk("dma_wr_addr",       0, sa, 32'h10);
    chk("dma_wr_data",       0, sw, 32'h1234);
    chk("dma_wr_no_read",    0, n_rd, 0);

    // DMA read leaves the CPU read register alone
    run_txn(0, 1'b1, 1'b0, 32'h80, 32'h0, 0, s_off, a_off, rd, sa, sw, n_rd, n_oth);
    chk("dma_rd_ack_off",  0, a_off, 3);
    chk("dma_rd_data",     0, rd, 32'h3CBCF070);
    chk("cpu_rdata_kept",  0, cpu_rdata[0], 32'hDEADBEEF);

    // both requesters held: owner pattern 0,0,0,0,1 repeating
    for (int i = 0; i < 10; i++) seq[i] = -1;
    cpu_we[0] = 1'b1; cpu_addr[0] = 32'h100; cpu_wdata[0] = 32'hC0C0;
    dma_we[0] = 1'b1; dma_addr[0] = 32'h200; dma_wdata[0] = 32'hD0D0;
    cpu_req[0] = 1'b1; dma_req[0] = 1'b1;
    g = 0;
    for (int i = 0; i < 120 && g < 10; i++) begin
      @(negedge clk);
      if (mem_write[0]) begin
        seq[g] = int'(owner[0]);
        g++;
      end
      tick();
    end
    cpu_req[0] = 1'b0; dma_req[0] = 1'b0;
    for (int i = 0; i < 10; i++) chk($sformatf("starve_owner_%0d", i), 0, seq[i], (i % 5 == 4) ? 1 : 0);
    repeat (6) tick();

    // DMA request raised and withdrawn while the CPU owns the memory
    cpu_we[0] = 1'b1; cpu_addr[0] = 32'h500; cpu_wdata[0] = 32'h55;
    cpu_req[0] = 1'b1;
    cnt_d = 0; cnt_c = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dma_ack[0]) cnt_d++;
      if (cpu_ack[0]) cnt_c++;
      tick();
      if (i == 0) begin dma_we[0] = 1'b0; dma_addr[0] = 32'h600; dma_req[0] = 1'b1; end
      if (i == 2) begin cpu_req[0] = 1'b0; dma_req[0] = 1'b0; end
    end
    chk("withdraw_no_dma_ack", 0, cnt_d, 0);
    chk("withdraw_cpu_acks",   0, cnt_c, 1);

    // back-to-back CPU reads, MEM_LAT=3
    for (int i = 0; i < 3; i++) begin s_c[i] = -100; a_c[i] = -100; end
    cpu_we[1] = 1'b0; cpu_addr[1] = 32'h300; cpu_req[1] = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (mem_read[1]) s_c[n] = cyc;
      if (cpu_ack[1]) begin a_c[n] = cyc; n++; end
      tick();
      cpu_addr[1] = 32'h300 + 32'(4 * n);
    end
    cpu_req[1] = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_ack_lat_%0d", i), 1, a_c[i] - (s_c[i] - 1), 5);
    for (int i = 0; i < 2; i++) chk($sformatf("b2b_gap_%0d", i), 1, s_c[i + 1] - a_c[i], 2);
    chk("b2b_last_data", 1, cpu_rdata[1], rd_fn(32'h308));

    // reset during WAIT, MEM_LAT=3
    tick();
    cpu_we[1] = 1'b0; cpu_addr[1] = 32'h44; cpu_req[1] = 1'b1;
    tick();
    tick();
    reset[1] = 1'b1;
    cpu_req[1] = 1'b0;
    tick();
    reset[1] = 1'b0;
    @(negedge clk);
    chk("rst_wait_busy",   1, 32'(busy[1]), 0);
    chk("rst_wait_ack",    1, 32'(cpu_ack[1]), 0);
    chk("rst_wait_read",   1, 32'(mem_read[1]), 0);
    chk("rst_wait_write",  1, 32'(mem_write[1]), 0);
    chk("rst_wait_rdata",  1, cpu_rdata[1], 0);
    tick();
    run_txn(1, 1'b0, 1'b0, 32'h48, 32'h0, 0, s_off, a_off, rd, sa, sw, n_rd, n_oth);
    chk("post_rst_strobe_off", 1, s_off, 1);
    chk("post_rst_ack_off",    1, a_off, 5);
    chk("post_rst_data",       1, rd, 32'h3C74F0B8);

    // cpu_req dropped during WAIT still completes
    run_txn(1, 1'b0, 1'b0, 32'h40, 32'h0, 2, s_off, a_off, rd, sa, sw, n_rd, n_oth);
    chk("drop_ack_off", 1, a_off, 5);
    chk("drop_data",    1, rd, 32'hDEADBEEF);

    // DMA write on the slow instance is unaffected by MEM_LAT
    run_txn(1, 1'b1, 1'b1, 32'h20, 32'hABCD, 0, s_off, a_off, rd, sa, sw, n_rd, n_oth);
    chk("slow_wr_ack_off", 1, a_off, 2);
    chk("slow_wr_data",    1, sw, 32'hABCD);

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
